// File: rtl/one_bit_dac_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : one_bit_dac_ctrl
// Brief    : Sample FIFO, clk_en strobe divider and sample scheduler feeding
//            the 1-bit sigma-delta DAC.
// Revision : 1.0 - initial release
// ============================================================================
module one_bit_dac_ctrl #(
    parameter int W          = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int PRIME_LVL  = FIFO_DEPTH / 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              osr_div,
    input  logic [7:0]                    spp,
    input  logic [W-1:0]                  s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    output logic                          dac_clk_en,
    output logic [W-1:0]                  dac_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    input  logic                          underrun_clr,
    output logic                          running
);

    localparam int                c_AW        = $clog2(FIFO_DEPTH);
    localparam int                c_LW        = c_AW + 1;
    localparam logic [c_LW-1:0]   c_DEPTH     = c_LW'(FIFO_DEPTH);
    localparam logic [c_LW-1:0]   c_PRIME_LVL = c_LW'(PRIME_LVL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_LW-1:0]    r_level;
    logic [DIV_W-1:0]   r_osr_div;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [7:0]         r_spp;
    logic [7:0]         r_str_cnt;
    logic               r_clk_en;
    logic               r_underrun;
    logic [W-1:0]       r_dac_in;

    logic               w_push;
    logic               w_boundary;
    logic               w_start;
    logic               w_play_pop;
    logic               w_underrun;
    logic               w_pop;

    assign s_tready   = (r_state != S_IDLE) && (r_level < c_DEPTH);
    assign w_push     = s_tvalid && s_tready;
    assign w_boundary = r_clk_en && (r_str_cnt == r_spp);
    assign w_start    = enable && (r_state == S_PRIME) && (r_level >= c_PRIME_LVL);
    // Pop decisions use the registered level, so a same-cycle push cannot rescue an underrun.
    assign w_play_pop = enable && (r_state == S_RUN) && w_boundary && (r_level != '0);
    assign w_underrun = enable && (r_state == S_RUN) && w_boundary && (r_level == '0);
    assign w_pop      = w_start || w_play_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_PRIME;
                S_PRIME: if (w_start)    w_state_nxt = S_RUN;
                S_RUN:   if (w_underrun) w_state_nxt = S_PRIME;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_osr_div <= '0;
            r_div_cnt <= '0;
            r_spp     <= '0;
            r_str_cnt <= '0;
            r_clk_en  <= 1'b0;
            r_dac_in  <= '0;
        end else if (!enable || (r_state == S_IDLE)) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_div_cnt <= '0;
            r_str_cnt <= '0;
            r_clk_en  <= 1'b0;
            r_dac_in  <= '0;
            if (enable) begin
                r_osr_div <= osr_div;
                r_spp     <= spp;
                // A divide-by-one divider strobes from the very first active cycle.
                r_clk_en  <= (osr_div == '0);
            end
        end else begin
            if (r_div_cnt == r_osr_div) begin
                r_div_cnt <= '0;
                r_clk_en  <= 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
                r_clk_en  <= 1'b0;
            end

            if (w_start) begin
                r_str_cnt <= '0;
            end else if (r_clk_en) begin
                r_str_cnt <= (r_str_cnt == r_spp) ? 8'd0 : r_str_cnt + 8'd1;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
                r_dac_in <= r_mem[r_rd_ptr];
            end else if (w_underrun) begin
                r_dac_in <= '0;
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_underrun <= 1'b0;
        end else if (w_underrun) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

    assign dac_clk_en = r_clk_en;
    assign dac_in     = r_dac_in;
    assign fifo_level = r_level;
    assign underrun   = r_underrun;
    assign running    = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_one_bit_dac_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_one_bit_dac_ctrl
// Brief    : Self-checking bench: queue-based playback model compared every
//            cycle, plus directed literal checks on key events.
// Revision : 1.0 - initial release
// ============================================================================
module tb_one_bit_dac_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] osr_div;
    logic [7:0]  spp;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        dac_clk_en;
    logic [15:0] dac_in;
    logic [4:0]  fifo_level;
    logic        underrun;
    logic        underrun_clr;
    logic        running;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    one_bit_dac_ctrl #(
        .W(16), .FIFO_DEPTH(16), .DIV_W(16), .PRIME_LVL(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .osr_div(osr_div), .spp(spp),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .dac_clk_en(dac_clk_en), .dac_in(dac_in), .fifo_level(fifo_level),
        .underrun(underrun), .underrun_clr(underrun_clr), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=idle 1=prime 2=run; k counts active cycles since leaving idle.
    int          m_mode = 0;
    logic [15:0] m_q[$];
    int          m_osr = 0;
    int          m_spp = 0;
    int          m_k = 0;
    int          m_nstr = 0;
    logic [15:0] m_dac = '0;
    bit          m_unr = 1'b0;
    bit          m_push;
    bit          m_set_u;

    function automatic bit m_strobe();
        return (m_mode != 0) && ((m_k % (m_osr + 1)) == 0) && (m_k > 0 || m_osr == 0);
    endfunction

    always @(posedge clk) begin
        m_push  = 1'b0;
        m_set_u = 1'b0;
        if (rst) begin
            m_mode = 0; m_q.delete(); m_dac = '0; m_k = 0; m_nstr = 0;
        end else if (!enable) begin
            m_mode = 0; m_q.delete(); m_dac = '0;
        end else begin
            m_push = (m_mode != 0) && s_tvalid && (m_q.size() < 16);
            case (m_mode)
                0: begin
                    m_mode = 1; m_osr = int'(osr_div); m_spp = int'(spp); m_k = 0;
                end
                1: begin
                    if (m_q.size() >= 8) begin
                        m_mode = 2; m_dac = m_q.pop_front(); m_nstr = 0;
                    end
                    m_k++;
                end
                default: begin
                    if (m_strobe()) begin
                        if (m_nstr == m_spp) begin
                            m_nstr = 0;
                            if (m_q.size() == 0) begin
                                m_dac = '0; m_set_u = 1'b1; m_mode = 1;
                            end else begin
                                m_dac = m_q.pop_front();
                            end
                        end else begin
                            m_nstr++;
                        end
                    end
                    m_k++;
                end
            endcase
            if (m_push) m_q.push_back(s_tdata);
        end
        if (rst) m_unr = 1'b0;
        else if (m_set_u) m_unr = 1'b1;
        else if (underrun_clr) m_unr = 1'b0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dac_clk_en", 32'(dac_clk_en), 32'(m_strobe()));
            chk("dac_in",     32'(dac_in),     32'(m_dac));
            chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
            chk("s_tready",   32'(s_tready),   32'((m_mode != 0) && (m_q.size() < 16)));
            chk("running",    32'(running),    32'(m_mode == 2));
            chk("underrun",   32'(underrun),   32'(m_unr));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; s_tvalid = 1'b1; s_tdata = 16'h0;
        osr_div = 16'd3; spp = 8'd1; underrun_clr = 1'b0;
        @(posedge clk); #2; chk_en = 1'b1;
        tick(2);
        chk("rst_s_tready", 32'(s_tready), 32'h0);
        chk("rst_dac_in",   32'(dac_in),   32'h0);
        chk("rst_level",    32'(fifo_level), 32'h0);
        chk("rst_running",  32'(running),  32'h0);
        rst = 1'b0; s_tvalid = 1'b0;
        tick(1);
        chk("prime_s_tready", 32'(s_tready), 32'h1);

        // Prefill 8 samples; active cycle k=0..7 carry the pushes.
        for (int i = 0; i < 8; i++) begin
            s_tdata = 16'h1000 + 16'(i); s_tvalid = 1'b1; tick(1);
        end
        s_tvalid = 1'b0;
        chk("prefill_not_running", 32'(running), 32'h0);
        tick(1);                                  // k=9
        chk("start_running", 32'(running), 32'h1);
        chk("start_dac_in",  32'(dac_in),  32'h1000);
        tick(3);                                  // k=12
        chk("strobe_k12", 32'(dac_clk_en), 32'h1);
        tick(5);                                  // k=17
        chk("second_sample", 32'(dac_in), 32'h1001);
        tick(8);                                  // k=25
        chk("third_sample", 32'(dac_in), 32'h1002);
        tick(47);                                 // k=72
        chk("last_sample", 32'(dac_in), 32'h1007);
        tick(1);                                  // k=73
        chk("unr_flag",    32'(underrun), 32'h1);
        chk("unr_running", 32'(running),  32'h0);
        chk("unr_dac_in",  32'(dac_in),   32'h0);

        for (int i = 0; i < 8; i++) begin
            s_tdata = 16'h2000 + 16'(i); s_tvalid = 1'b1; tick(1);
        end
        s_tvalid = 1'b0;
        tick(1);                                  // k=82
        chk("resume_running", 32'(running), 32'h1);
        chk("resume_dac_in",  32'(dac_in),  32'h2000);
        chk("unr_sticky",     32'(underrun), 32'h1);
        underrun_clr = 1'b1; tick(1);             // k=83
        underrun_clr = 1'b0;
        chk("unr_cleared", 32'(underrun), 32'h0);

        osr_div = 16'd7;                          // ignored until next idle exit
        tick(1);
        chk("latch_k84", 32'(dac_clk_en), 32'h1);
        tick(2);
        chk("latch_k86", 32'(dac_clk_en), 32'h0);
        tick(2);
        chk("latch_k88", 32'(dac_clk_en), 32'h1);

        enable = 1'b0; tick(1);
        chk("dis_running", 32'(running),    32'h0);
        chk("dis_clk_en",  32'(dac_clk_en), 32'h0);
        chk("dis_dac_in",  32'(dac_in),     32'h0);
        chk("dis_level",   32'(fifo_level), 32'h0);
        chk("dis_s_tready", 32'(s_tready),  32'h0);
        tick(2);
        enable = 1'b1; tick(1);                   // PRIME k=0, period now 8
        tick(7);
        chk("osr7_k7", 32'(dac_clk_en), 32'h0);
        tick(1);
        chk("osr7_k8", 32'(dac_clk_en), 32'h1);

        enable = 1'b0; tick(1);
        osr_div = 16'd0; enable = 1'b1; tick(1);
        for (int i = 0; i < 5; i++) begin
            chk("osr0_continuous", 32'(dac_clk_en), 32'h1);
            tick(1);
        end

        enable = 1'b0; tick(1);
        osr_div = 16'hFFFF; enable = 1'b1; tick(1);
        s_tvalid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            s_tdata = 16'h3000 + 16'(i); tick(1);
        end
        chk("full_level",    32'(fifo_level), 32'd16);
        chk("full_s_tready", 32'(s_tready),   32'h0);
        chk("full_dac_in",   32'(dac_in),     32'h3000);
        tick(3);
        chk("full_level_hold", 32'(fifo_level), 32'd16);
        s_tvalid = 1'b0;
        tick(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
